// File: rtl/sseg_share_ctrl.sv
// Shared 8-digit seven-segment display scheduler: round-robin ownership with a
// minimum hold, frame-aligned hand-over, and an owner-writable frame buffer.
module sseg_share_ctrl #(
  parameter int SCAN_BITS   = 18,
  parameter int HOLD_FRAMES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       wr_en_0_i,
  input  logic       wr_en_1_i,
  input  logic [2:0] wr_addr_0_i,
  input  logic [2:0] wr_addr_1_i,
  input  logic [7:0] wr_data_0_i,
  input  logic [7:0] wr_data_1_i,
  output logic [1:0] gnt_o,
  output logic [1:0] wr_ack_o,
  output logic       frame_tick_o,
  output logic [7:0] sseg_o,
  output logic [7:0] an_o
);

  localparam int             CW       = SCAN_BITS + 3;
  localparam logic [CW-1:0]  SCAN_ONE = CW'(1);
  localparam logic [4:0]     HOLD_MAX = 5'(HOLD_FRAMES);

  logic [CW-1:0] scan_q;
  logic [2:0]    digit;
  logic [1:0]    gnt_q, gnt_d;
  logic [3:0]    hold_q, hold_d;
  logic [4:0]    hold_inc;
  logic          hold_met;
  logic          last_q;
  logic          sw;
  logic [7:0]    fb_q [8];
  logic [7:0]    sseg_q, an_q;

  assign digit        = scan_q[CW-1 -: 3];
  assign frame_tick_o = &scan_q;

  always_comb begin
    gnt_d    = gnt_q;
    hold_d   = hold_q;
    hold_inc = {1'b0, hold_q} + 5'd1;
    hold_met = (hold_inc >= HOLD_MAX);
    if (frame_tick_o) begin
      case (gnt_q)
        2'b01: begin
          if (!req_i[0])                  gnt_d = req_i[1] ? 2'b10 : 2'b00;
          else if (req_i[1] && hold_met)  gnt_d = 2'b10;
        end
        2'b10: begin
          if (!req_i[1])                  gnt_d = req_i[0] ? 2'b01 : 2'b00;
          else if (req_i[0] && hold_met)  gnt_d = 2'b01;
        end
        default: begin
          // last_q = 1 means requester 1 owned most recently, so 0 wins a tie
          case (req_i)
            2'b01:   gnt_d = 2'b01;
            2'b10:   gnt_d = 2'b10;
            2'b11:   gnt_d = last_q ? 2'b01 : 2'b10;
            default: gnt_d = 2'b00;
          endcase
        end
      endcase
    end
    sw = frame_tick_o && (gnt_d != gnt_q);
    if (sw)
      hold_d = 4'd0;
    else if (frame_tick_o && ({1'b0, hold_q} < HOLD_MAX))
      hold_d = hold_q + 4'd1;
  end

  assign wr_ack_o = {wr_en_1_i & gnt_q[1], wr_en_0_i & gnt_q[0]} & {2{~sw}};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scan_q <= '0;
      gnt_q  <= 2'b00;
      hold_q <= 4'd0;
      last_q <= 1'b1;
    end else begin
      scan_q <= scan_q + SCAN_ONE;
      gnt_q  <= gnt_d;
      hold_q <= hold_d;
      if (sw && (gnt_d != 2'b00))
        last_q <= gnt_d[1];
    end
  end

  // a hand-over blanks the whole buffer so the new owner never shows stale data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) fb_q[i] <= 8'hFF;
    end else if (sw) begin
      for (int i = 0; i < 8; i++) fb_q[i] <= 8'hFF;
    end else begin
      if (wr_ack_o[0]) fb_q[wr_addr_0_i] <= wr_data_0_i;
      if (wr_ack_o[1]) fb_q[wr_addr_1_i] <= wr_data_1_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sseg_q <= 8'hFF;
      an_q   <= 8'hFF;
    end else begin
      sseg_q <= (gnt_q == 2'b00) ? 8'hFF : fb_q[digit];
      an_q   <= ~(8'b1 << digit);
    end
  end

  assign gnt_o  = gnt_q;
  assign sseg_o = sseg_q;
  assign an_o   = an_q;

endmodule

// File: tb/tb_sseg_share_ctrl.sv
// Directed bench for sseg_share_ctrl with SCAN_BITS=2 (32-cycle frame) and HOLD_FRAMES=2.
module tb_sseg_share_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic       en0 = 1'b0, en1 = 1'b0;
  logic [2:0] a0 = 3'd0, a1 = 3'd0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic [1:0] gnt, wr_ack;
  logic       frame_tick;
  logic [7:0] sseg, an;

  sseg_share_ctrl #(.SCAN_BITS(2), .HOLD_FRAMES(2)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .wr_en_0_i(en0), .wr_en_1_i(en1),
    .wr_addr_0_i(a0), .wr_addr_1_i(a1),
    .wr_data_0_i(d0), .wr_data_1_i(d1),
    .gnt_o(gnt), .wr_ack_o(wr_ack), .frame_tick_o(frame_tick),
    .sseg_o(sseg), .an_o(an)
  );

  always #5 clk = ~clk;

  // posedges since the last reset release; equals the DUT scan count mod 32
  int cyc;
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_fb [8];
  logic [1:0] exp_gnt;

  typedef struct {
    logic [1:0] req;
    logic       en0;
    logic [2:0] a0;
    logic [7:0] d0;
    logic       en1;
    logic [2:0] a1;
    logic [7:0] d1;
    logic [1:0] ack;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic go(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) exp_fb[i] = 8'hFF;
  endtask

  // checks n consecutive cycles of scan output against the buffer model
  task automatic scan_chk(input int n);
    int d;
    logic [7:0] e_an, e_seg;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      d     = ((cyc - 1) % 32) / 4;
      e_an  = ~(8'b1 << d);
      e_seg = (exp_gnt != 2'b00) ? exp_fb[d] : 8'hFF;
      chk("an", an, e_an);
      chk("sseg", sseg, e_seg);
      chk("frame_tick", frame_tick, ((cyc % 32) == 31));
      chk("gnt", gnt, exp_gnt);
    end
  endtask

  initial begin
    //        req    en0   a0    d0      en1   a1    d1      ack
    vecs[0] = '{2'b01, 1'b1, 3'd3, 8'h9C, 1'b0, 3'd0, 8'h00, 2'b01};
    vecs[1] = '{2'b01, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h00, 2'b00};
    vecs[2] = '{2'b01, 1'b1, 3'd6, 8'h12, 1'b1, 3'd6, 8'h34, 2'b01};
    vecs[3] = '{2'b01, 1'b0, 3'd1, 8'h55, 1'b0, 3'd1, 8'h66, 2'b00};
    vecs[4] = '{2'b01, 1'b1, 3'd0, 8'hC0, 1'b0, 3'd0, 8'h00, 2'b01};
    vecs[5] = '{2'b01, 1'b1, 3'd7, 8'hF9, 1'b1, 3'd2, 8'h00, 2'b01};
    clear_model();
    exp_gnt = 2'b00;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_an", an, 8'hFF);
    chk("rst_sseg", sseg, 8'hFF);
    chk("rst_tick", frame_tick, 1'b0);
    rst = 1'b0;

    // idle scan over two frames
    scan_chk(64);

    // single grant, then table-driven writes from both sides
    req = 2'b01;
    go(95);
    chk("pre_grant_gnt", gnt, 2'b00);
    chk("tick_at_95", frame_tick, 1'b1);
    go(96);
    chk("grant0_gnt", gnt, 2'b01);
    exp_gnt = 2'b01;
    for (int i = 0; i < 6; i++) begin
      req = vecs[i].req;
      en0 = vecs[i].en0; a0 = vecs[i].a0; d0 = vecs[i].d0;
      en1 = vecs[i].en1; a1 = vecs[i].a1; d1 = vecs[i].d1;
      #1;
      chk($sformatf("vec%0d_wr_ack", i), wr_ack, vecs[i].ack);
      if (vecs[i].ack[0]) exp_fb[vecs[i].a0] = vecs[i].d0;
      if (vecs[i].ack[1]) exp_fb[vecs[i].a1] = vecs[i].d1;
      @(negedge clk);
    end
    en0 = 1'b0; en1 = 1'b0;
    go(128);
    scan_chk(32);

    // reset mid-operation with a write pending
    go(170);
    en0 = 1'b1; a0 = 3'd1; d0 = 8'h11;
    #1;
    chk("pre_rst_ack", wr_ack, 2'b01);
    rst = 1'b1;
    #1;
    chk("midrst_gnt", gnt, 2'b00);
    chk("midrst_an", an, 8'hFF);
    chk("midrst_sseg", sseg, 8'hFF);
    chk("midrst_ack", wr_ack, 2'b00);
    @(negedge clk);
    chk("midrst_an_held", an, 8'hFF);
    en0 = 1'b0;
    req = 2'b11;
    rst = 1'b0;
    clear_model();
    exp_gnt = 2'b00;

    // contention from reset: 0 first, switch after tick 3, then every 2 frames
    go(31);
    chk("c_tick1_gnt", gnt, 2'b00);
    chk("c_tick1", frame_tick, 1'b1);
    go(32);
    chk("c_grant0", gnt, 2'b01);
    exp_gnt = 2'b01;
    scan_chk(31);
    go(64);
    chk("c_hold_gnt", gnt, 2'b01);
    go(70);
    en0 = 1'b1; a0 = 3'd2; d0 = 8'hA4;
    #1;
    chk("c_wr0_ack", wr_ack, 2'b01);
    @(negedge clk);
    en0 = 1'b0;
    go(73);
    chk("c_wr0_an", an, 8'hFB);
    chk("c_wr0_sseg", sseg, 8'hA4);
    go(95);
    en0 = 1'b1; a0 = 3'd2; d0 = 8'h55;
    #1;
    chk("sw_wr_ack", wr_ack, 2'b00);
    chk("sw_tick", frame_tick, 1'b1);
    chk("sw_pre_gnt", gnt, 2'b01);
    @(negedge clk);
    en0 = 1'b0;
    chk("c_switch1_gnt", gnt, 2'b10);
    clear_model();
    exp_gnt = 2'b10;
    go(100);
    en1 = 1'b1; a1 = 3'd4; d1 = 8'h66;
    #1;
    chk("c_wr1_ack", wr_ack, 2'b10);
    exp_fb[4] = 8'h66;
    @(negedge clk);
    en1 = 1'b0;
    go(128);
    chk("c_hold1_gnt", gnt, 2'b10);
    scan_chk(31);
    go(160);
    chk("c_switch2_gnt", gnt, 2'b01);
    clear_model();
    exp_gnt = 2'b01;

    // release mid-frame with no other requester
    go(165);
    req = 2'b00;
    go(190);
    chk("rel_mid_gnt", gnt, 2'b01);
    go(191);
    chk("rel_tick_gnt", gnt, 2'b01);
    chk("rel_tick", frame_tick, 1'b1);
    go(192);
    chk("rel_gnt", gnt, 2'b00);
    exp_gnt = 2'b00;
    scan_chk(32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
